inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch responder for the five-stage MIPS pipeline. Consumes the fetch address `pc` and enable `ce` produced by the PC stage and runs a req/ack read on the instruction memory port. Registers the returned word into the IF/ID boundary, requests a pipeline stall while memory wait states are pending, and discards in-flight fetches on a taken branch.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait-state limit before a fetch is abandoned. Used only when `IFETCH_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_i` in 32: fetch address from the PC stage.
- `ce_i` in 1: fetch enable from the PC stage; 1 = enabled.
- `stall_i` in 6: pipeline stall vector from the stall controller. `stall_i[1]` is the IF/ID stall bit and `stall_i[2]` is the ID stall bit.
- `flush_i` in 1: taken branch; discard the current fetch.
- `mem_req_o` out 1: memory read request.
- `mem_addr_o` out 32: memory read address.
- `mem_ack_i` in 1: memory read data valid.
- `mem_rdata_i` in 32: memory read data.
- `inst_o` out 32: instruction to ID.
- `inst_pc_o` out 32: address of `inst_o`.
- `inst_valid_o` out 1: `inst_o` is a real fetch; 0 = bubble.
- `stallreq_o` out 1: stall request to the stall controller.
- `fetch_err_o` out 1: fetch timeout pulse.

## Operation
States:
- ISSUE: normal fetch.
- HOLD: data captured while IF/ID is stalled.
- DROP: flushed request still outstanding.

Request rule:
- ISSUE: `mem_req_o = ce_i & ~flush_i & ~rst` and `mem_addr_o = pc_i`.
- DROP: `mem_req_o = 1` and `mem_addr_o = drop_addr`.
- HOLD: `mem_req_o = 0`.
- Once `mem_req_o` is raised, it and `mem_addr_o` stay stable until the cycle `mem_ack_i = 1`. The only exception is a timeout.

ISSUE behaviour:
- `req & ack & ~stall_i[1]`: load `inst_o = mem_rdata_i`, `inst_pc_o = pc_i`, `inst_valid_o = 1`. Stay in ISSUE.
- `req & ack & stall_i[1]`: capture data and address into the skid register, go to HOLD.
- `req & ~ack & flush_i` on a later cycle of an outstanding request: latch the old address into `drop_addr`, go to DROP.

HOLD behaviour:
- Wait until `stall_i[1] = 0`.
- Then load `inst_o`, `inst_pc_o`, `inst_valid_o = 1` from the skid register and return to ISSUE.

DROP behaviour:
- Wait for `mem_ack_i`, discard the data, return to ISSUE.
- Meanwhile `pc_i` already carries the branch target.

`stallreq_o`:
- `= 1` in ISSUE when `mem_req_o & ~mem_ack_i`.
- `= 1` in DROP when `~mem_ack_i`.
- `= 0` in HOLD.

IF/ID output register, in priority order:
1. `rst`: all outputs zero.
2. `flush_i`: `inst_o = 0`, `inst_valid_o = 0`.
3. `stall_i[1] & ~stall_i[2]`: bubble, `inst_o = 0`, `inst_valid_o = 0`.
4. `stall_i[1] & stall_i[2]`: hold.
5. Otherwise: update as above. A cycle with no ack and no stall gives a bubble.

Reset values:
- `inst_o`, `inst_pc_o`, `inst_valid_o`, `fetch_err_o`, skid register and `drop_addr` are 0.
- State is ISSUE.
- `mem_req_o` and `stallreq_o` are 0 while `rst = 1`.
- Reset during ISSUE wait, HOLD or DROP abandons the transaction; memory tolerates dropped requests on reset.

Flush interactions:
- `flush_i` in HOLD discards the skid data and returns to ISSUE.
- `flush_i` and `ack` in the same ISSUE cycle: data discarded, no DROP.

## Timing
- Zero-wait memory (ack in the same cycle as req): `inst_o` is valid one edge after `pc_i`, giving one instruction per cycle.
- N wait states: `stallreq_o` is high for N cycles, and `inst_o` updates on the edge after ack.
- All outputs except `mem_req_o`, `mem_addr_o` and `stallreq_o` are registered.
- No combinational path from `stall_i` to `mem_req_o`, `mem_addr_o` or `stallreq_o`.
- The stall controller does not stall the PC on a `flush_i` cycle, so the branch target loads into `pc_i` at that edge.

## Configuration
`IFETCH_TIMEOUT_EN`:
- Defined:
  - An 8-bit-minimum counter increments on each cycle with `mem_req_o & ~mem_ack_i` and clears on ack, on a state change or on `rst`.
  - On the cycle the count reaches `TIMEOUT_CYCLES`: `fetch_err_o` pulses 1 for one cycle and `mem_req_o` is forced 0.
  - Next edge: IF/ID receives a bubble and the state goes to ISSUE.
- Undefined:
  - No counter; `fetch_err_o` is tied 0.
  - Requests wait indefinitely for ack.

## Test plan
- Reset, then `ce_i = 1`, `pc_i` = 0, 4, 8 with ack in the same cycle as req → `inst_o` = mem[0], mem[4], mem[8] on consecutive cycles, `inst_valid_o = 1`, `stallreq_o = 0`.
- `pc_i = 0x40`, ack delayed 3 cycles → `stallreq_o` high 3 cycles with `mem_addr_o = 0x40` stable; bubbles on `inst_o`; then `inst_o` = mem[0x40], `inst_pc_o = 0x40`.
- `flush_i` on the 2nd wait cycle of fetch 0x80, `pc_i` → 0x200 → `mem_addr_o` stays 0x80 until ack; that data is dropped; next fetch 0x200; `inst_valid_o = 0` until mem[0x200] appears.
- Ack at 0x10 with `stall_i = 6'b000111` for 2 cycles → `mem_req_o = 0` during HOLD; `inst_o` holds its old value; mem[0x10] appears on the first cycle after the stall clears.
- `rst` pulsed during a wait → outputs zeroed, state ISSUE, `mem_req_o = 0` during reset.
- With `IFETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES = 4`, ack never asserted → `fetch_err_o` pulses one cycle at the 4th wait cycle; bubble follows; without the macro, `stallreq_o` stays high.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch responder: req/ack memory read into the IF/ID register.
// Optional wait-state timeout enabled by defining IFETCH_TIMEOUT_EN.
module inst_fetch #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stallreq_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        ISSUE,
        HOLD,
        DROP
    } state_t;

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] skid_inst_q, skid_pc_q, drop_addr_q;
    logic        req_raw, timeout;
    logic        load_mem, load_skid, cap_skid, latch_drop;
    logic        unused;

    assign unused = ^{stall_i[5:3], stall_i[0]};

    // An outstanding ISSUE request ignores flush/ce so the bus stays stable.
    assign req_raw = (state_q == ISSUE) ? (pending_q | (ce_i & ~flush_i))
                                        : (state_q == DROP);
    assign mem_req_o  = req_raw & ~timeout & ~rst;
    assign mem_addr_o = (state_q == DROP) ? drop_addr_q : pc_i;
    assign stallreq_o = mem_req_o & ~mem_ack_i;

    always_comb begin
        state_d    = state_q;
        pending_d  = 1'b0;
        load_mem   = 1'b0;
        load_skid  = 1'b0;
        cap_skid   = 1'b0;
        latch_drop = 1'b0;
        unique case (state_q)
            ISSUE: begin
                if (mem_req_o && mem_ack_i) begin
                    if (!flush_i) begin
                        if (stall_i[1]) begin
                            cap_skid = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            load_mem = 1'b1;
                        end
                    end
                end else if (mem_req_o && pending_q && flush_i) begin
                    latch_drop = 1'b1;
                    state_d    = DROP;
                end else begin
                    pending_d = mem_req_o;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = ISSUE;
                end else if (!stall_i[1]) begin
                    load_skid = 1'b1;
                    state_d   = ISSUE;
                end
            end
            DROP: begin
                if (timeout || mem_ack_i) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ISSUE;
            pending_q   <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            drop_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (cap_skid) begin
                skid_inst_q <= mem_rdata_i;
                skid_pc_q   <= pc_i;
            end
            if (latch_drop) drop_addr_q <= pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else if (flush_i || (stall_i[1] && !stall_i[2])) begin
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end else if (stall_i[1]) begin
            inst_o       <= inst_o;
        end else if (load_mem) begin
            inst_o       <= mem_rdata_i;
            inst_pc_o    <= pc_i;
            inst_valid_o <= 1'b1;
        end else if (load_skid) begin
            inst_o       <= skid_inst_q;
            inst_pc_o    <= skid_pc_q;
            inst_valid_o <= 1'b1;
        end else begin
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] wait_cnt_q;
    logic          err_q;

    // err_q is armed one cycle early so the pulse lands on the final wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (stallreq_o && state_d == state_q) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
                err_q      <= (int'(wait_cnt_q) + 2 >= TIMEOUT_CYCLES);
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    assign timeout     = err_q;
    assign fetch_err_o = err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; the timeout scenario follows IFETCH_TIMEOUT_EN.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stallreq_o;
    logic        fetch_err_o;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .inst_o      (inst_o),
        .inst_pc_o   (inst_pc_o),
        .inst_valid_o(inst_valid_o),
        .stallreq_o  (stallreq_o),
        .fetch_err_o (fetch_err_o)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b1; pc_i = 32'h0; stall_i = '0;
        flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++; $display("FAIL rst_req got %b want 0", mem_req_o);
        end
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++; $display("FAIL rst_stallreq got %b want 0", stallreq_o);
        end
        cyc(); cyc();
        checks++;
        if ({inst_o, inst_pc_o, inst_valid_o, fetch_err_o} !== 66'h0) begin
            errors++;
            $display("FAIL rst_outs got %h %h %b %b want zeros",
                     inst_o, inst_pc_o, inst_valid_o, fetch_err_o);
        end
        rst = 1'b0; ce_i = 1'b0; mem_ack_i = 1'b0;
        cyc();
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 3; i++) begin
            pc_i = 32'(i * 4); ce_i = 1'b1; mem_ack_i = 1'b1;
            mem_rdata_i = 32'hC0DE_0000 | 32'(i * 4);
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || stallreq_o !== 1'b0) begin
                errors++;
                $display("FAIL zw_req[%0d] got req=%b stall=%b want 1 0",
                         i, mem_req_o, stallreq_o);
            end
            cyc();
            checks++;
            if (inst_o !== (32'hC0DE_0000 | 32'(i * 4)) ||
                inst_pc_o !== 32'(i * 4) || inst_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL zw_inst[%0d] got %h pc=%h v=%b", i,
                         inst_o, inst_pc_o, inst_valid_o);
            end
        end
        ce_i = 1'b0; mem_ack_i = 1'b0;
        cyc();
        checks++;
        if (inst_o !== 32'h0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zw_bubble got %h v=%b want 0 0", inst_o, inst_valid_o);
        end
    endtask

    task automatic test_wait_states();
        pc_i = 32'h40; ce_i = 1'b1; mem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 ||
                stallreq_o !== 1'b1) begin
                errors++;
                $display("FAIL ws_wait[%0d] got req=%b addr=%h stall=%b",
                         i, mem_req_o, mem_addr_o, stallreq_o);
            end
            cyc();
            checks++;
            if (inst_o !== 32'h0 || inst_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL ws_bubble[%0d] got %h v=%b", i, inst_o, inst_valid_o);
            end
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hC0DE_0040;
        #1;
        checks++;
        if (stallreq_o !== 1'b0 || mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL ws_ack got stall=%b req=%b want 0 1", stallreq_o, mem_req_o);
        end
        cyc();
        checks++;
        if (inst_o !== 32'hC0DE_0040 || inst_pc_o !== 32'h40 ||
            inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ws_inst got %h pc=%h v=%b", inst_o, inst_pc_o, inst_valid_o);
        end
        ce_i = 1'b0; mem_ack_i = 1'b0;
        cyc();
    endtask

    task automatic test_flush_drop();
        pc_i = 32'h80; ce_i = 1'b1; mem_ack_i = 1'b0;
        cyc();
        flush_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80 || stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL fd_flushcyc got req=%b addr=%h stall=%b",
                     mem_req_o, mem_addr_o, stallreq_o);
        end
        cyc();
        flush_i = 1'b0; pc_i = 32'h200;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h80 || stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL fd_drop got req=%b addr=%h stall=%b want 1 80 1",
                     mem_req_o, mem_addr_o, stallreq_o);
        end
        cyc();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hC0DE_0080;
        #1;
        checks++;
        if (mem_addr_o !== 32'h80 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL fd_dropack got addr=%h stall=%b", mem_addr_o, stallreq_o);
        end
        cyc();
        checks++;
        if (inst_valid_o !== 1'b0 || inst_o !== 32'h0) begin
            errors++;
            $display("FAIL fd_discard got %h v=%b want 0 0", inst_o, inst_valid_o);
        end
        mem_rdata_i = 32'hC0DE_0200;
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
            errors++;
            $display("FAIL fd_target got req=%b addr=%h", mem_req_o, mem_addr_o);
        end
        cyc();
        checks++;
        if (inst_o !== 32'hC0DE_0200 || inst_pc_o !== 32'h200 ||
            inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL fd_inst got %h pc=%h v=%b", inst_o, inst_pc_o, inst_valid_o);
        end
        ce_i = 1'b0; mem_ack_i = 1'b0;
        cyc();
    endtask

    task automatic test_flush_with_ack();
        pc_i = 32'h30; ce_i = 1'b1; mem_ack_i = 1'b0;
        cyc();
        flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hC0DE_0030;
        cyc();
        flush_i = 1'b0; pc_i = 32'h300; mem_rdata_i = 32'hC0DE_0300;
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL fa_discard got v=%b want 0", inst_valid_o);
        end
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300) begin
            errors++;
            $display("FAIL fa_nodrop got req=%b addr=%h want 1 300",
                     mem_req_o, mem_addr_o);
        end
        cyc();
        checks++;
        if (inst_o !== 32'hC0DE_0300 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL fa_inst got %h v=%b", inst_o, inst_valid_o);
        end
        ce_i = 1'b0; mem_ack_i = 1'b0;
        cyc();
    endtask

    task automatic test_hold();
        pc_i = 32'h0C; ce_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hC0DE_000C;
        cyc();
        pc_i = 32'h10; mem_rdata_i = 32'hC0DE_0010; stall_i = 6'b000111;
        #1;
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL hd_req got %b want 1", mem_req_o);
        end
        cyc();
        mem_ack_i = 1'b0;
        checks++;
        if (inst_o !== 32'hC0DE_000C || inst_valid_o !== 1'b1) begin
            errors++; $display("FAIL hd_keep1 got %h v=%b", inst_o, inst_valid_o);
        end
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL hd_noreq got req=%b stall=%b", mem_req_o, stallreq_o);
        end
        cyc();
        stall_i = '0;
        checks++;
        if (inst_o !== 32'hC0DE_000C) begin
            errors++; $display("FAIL hd_keep2 got %h want c0de000c", inst_o);
        end
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++; $display("FAIL hd_release_req got %b want 0", mem_req_o);
        end
        cyc();
        checks++;
        if (inst_o !== 32'hC0DE_0010 || inst_pc_o !== 32'h10 ||
            inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL hd_inst got %h pc=%h v=%b", inst_o, inst_pc_o, inst_valid_o);
        end
        ce_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        pc_i = 32'h50; ce_i = 1'b1; mem_ack_i = 1'b0;
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            errors++; $display("FAIL rw_wait got stall=%b want 1", stallreq_o);
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL rw_req got req=%b stall=%b want 0 0", mem_req_o, stallreq_o);
        end
        cyc();
        checks++;
        if (inst_o !== 32'h0 || inst_pc_o !== 32'h0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rw_outs got %h pc=%h v=%b", inst_o, inst_pc_o, inst_valid_o);
        end
        rst = 1'b0; ce_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin
            errors++; $display("FAIL rw_abandon got req=%b want 0", mem_req_o);
        end
        cyc();
    endtask

    task automatic test_timeout();
        pc_i = 32'h60; ce_i = 1'b1; mem_ack_i = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_req_o !== 1'b1 || fetch_err_o !== 1'b0) begin
                errors++;
                $display("FAIL to_wait[%0d] got req=%b err=%b", i, mem_req_o, fetch_err_o);
            end
            cyc();
        end
        checks++;
        if (fetch_err_o !== 1'b1 || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got err=%b req=%b stall=%b want 1 0 0",
                     fetch_err_o, mem_req_o, stallreq_o);
        end
        cyc();
        checks++;
        if (fetch_err_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL to_after got err=%b v=%b want 0 0", fetch_err_o, inst_valid_o);
        end
`else
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (stallreq_o !== 1'b1 || fetch_err_o !== 1'b0) begin
                errors++;
                $display("FAIL to_forever[%0d] got stall=%b err=%b want 1 0",
                         i, stallreq_o, fetch_err_o);
            end
            cyc();
        end
`endif
        mem_ack_i = 1'b1; mem_rdata_i = 32'hC0DE_0060;
        cyc();
        ce_i = 1'b0; mem_ack_i = 1'b0;
        checks++;
        if (inst_o !== 32'hC0DE_0060 || inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL to_recover got %h v=%b", inst_o, inst_valid_o);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_flush_drop();
        test_flush_with_ack();
        test_hold();
        test_reset_mid_wait();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
